// File: rtl/panel_scan_if.sv
// panel_scan_if: framebuffer read port between panel_scan and the writer.
// master = scanner (addr/bank out, pixels in); slave = framebuffer side.
interface panel_scan_if;
  logic        display;
  logic        rd_bank;
  logic [8:0]  rd_addr_top;
  logic [8:0]  rd_addr_bot;
  logic [23:0] rgb_top;
  logic [23:0] rgb_bot;

  modport master (
    input  display, rgb_top, rgb_bot,
    output rd_bank, rd_addr_top, rd_addr_bot
  );

  modport slave (
    output display, rgb_top, rgb_bot,
    input  rd_bank, rd_addr_top, rd_addr_bot
  );
endinterface

// File: rtl/panel_scan.sv
// panel_scan: 1/8-scan HUB75 driver with BCM over BITS bitplanes.
// Ports: pixclk, reset (sync, high), fb (read port), r1/g1/b1, r2/g2/b2,
// row_sel, panel_clk, panel_lat, panel_oe (low = lit), frame_start.
// Option PANEL_SCAN_GAMMA_EN: registered (c*c)>>8 on every channel.
module panel_scan #(
  parameter int BITS = 8,
  parameter int BASE = 4,
  parameter int COLS = 32
) (
  input  logic         pixclk,
  input  logic         reset,
  panel_scan_if.master fb,
  output logic         r1,
  output logic         g1,
  output logic         b1,
  output logic         r2,
  output logic         g2,
  output logic         b2,
  output logic [2:0]   row_sel,
  output logic         panel_clk,
  output logic         panel_lat,
  output logic         panel_oe,
  output logic         frame_start
);

`ifdef PANEL_SCAN_GAMMA_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 1;
`endif

  localparam logic [15:0] SH_LAST = 16'(2 * COLS + PRE - 1);
  localparam logic [15:0] PRE_W   = 16'(PRE);
  localparam logic [2:0]  LAST_PL = 3'(BITS - 1);
  localparam logic [2:0]  IDX0    = 3'(8 - BITS);

  typedef enum logic [1:0] {
    SHIFT, LATCH, SHOW
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] show_last;
  logic [2:0]  row_q, row_d;
  logic [2:0]  plane_q, plane_d;
  logic        first_q;
  logic        boundary;
  logic        clk_d;
  logic [4:0]  col_d;
  logic        disp_s1_q, disp_s2_q;
  logic        bank_q;
  logic [8:0]  addr_top_q, addr_bot_q;
  logic [2:0]  row_sel_q;
  logic        pclk_q, plat_q, poe_q, fs_q;
  logic        en_q;
  logic [23:0] pix_top, pix_bot;
  logic [2:0]  idx;

  always_comb begin
    show_last = (16'(BASE) << plane_q) - 16'd1;
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    row_d     = row_q;
    plane_d   = plane_q;
    // First edge after reset re-enters SHIFT so the frame start is seen.
    if (first_q) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (cnt_q == SH_LAST) begin
            state_d = LATCH;
            cnt_d   = '0;
          end
        end
        LATCH: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
        SHOW: begin
          if (cnt_q == show_last) begin
            state_d = SHIFT;
            cnt_d   = '0;
            if (plane_q == LAST_PL) begin
              plane_d = '0;
              row_d   = row_q + 3'd1;
            end else begin
              plane_d = plane_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      endcase
    end
    boundary = (first_q || (state_q == SHOW && state_d == SHIFT))
             && row_d == 3'd0 && plane_d == 3'd0;
    col_d = cnt_d[5:1];
    // Rising shift edge on every second cycle after the prefetch.
    clk_d = state_d == SHIFT && cnt_d > PRE_W
          && cnt_d[0] != PRE_W[0];
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q    <= SHIFT;
      cnt_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      first_q    <= 1'b1;
      disp_s1_q  <= 1'b0;
      disp_s2_q  <= 1'b0;
      bank_q     <= 1'b0;
      addr_top_q <= '0;
      addr_bot_q <= '0;
      row_sel_q  <= '0;
      pclk_q     <= 1'b0;
      plat_q     <= 1'b0;
      poe_q      <= 1'b1;
      fs_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      first_q   <= 1'b0;
      disp_s1_q <= fb.display;
      disp_s2_q <= disp_s1_q;
      if (boundary) bank_q <= disp_s2_q;
      if (state_d == SHIFT) begin
        addr_top_q <= {1'b0, row_d, col_d};
        addr_bot_q <= {1'b1, row_d, col_d};
      end
      if (state_d == LATCH) row_sel_q <= row_d;
      pclk_q <= clk_d;
      plat_q <= state_d == LATCH;
      poe_q  <= state_d != SHOW;
      fs_q   <= boundary;
      en_q   <= state_d == SHIFT && cnt_d >= PRE_W;
    end
  end

`ifdef PANEL_SCAN_GAMMA_EN
  function automatic logic [7:0] gam(input logic [7:0] c);
    return 8'((16'(c) * 16'(c)) >> 8);
  endfunction

  logic [23:0] pix_top_q, pix_bot_q;

  always_ff @(posedge pixclk) begin
    if (reset) begin
      pix_top_q <= '0;
      pix_bot_q <= '0;
    end else begin
      pix_top_q <= {gam(fb.rgb_top[23:16]),
                    gam(fb.rgb_top[15:8]),
                    gam(fb.rgb_top[7:0])};
      pix_bot_q <= {gam(fb.rgb_bot[23:16]),
                    gam(fb.rgb_bot[15:8]),
                    gam(fb.rgb_bot[7:0])};
    end
  end

  assign pix_top = pix_top_q;
  assign pix_bot = pix_bot_q;
`else
  assign pix_top = fb.rgb_top;
  assign pix_bot = fb.rgb_bot;
`endif

  assign idx = IDX0 + plane_q;

  assign r1 = en_q & pix_top[{2'b10, idx}];
  assign g1 = en_q & pix_top[{2'b01, idx}];
  assign b1 = en_q & pix_top[{2'b00, idx}];
  assign r2 = en_q & pix_bot[{2'b10, idx}];
  assign g2 = en_q & pix_bot[{2'b01, idx}];
  assign b2 = en_q & pix_bot[{2'b00, idx}];

  assign fb.rd_bank     = bank_q;
  assign fb.rd_addr_top = addr_top_q;
  assign fb.rd_addr_bot = addr_bot_q;
  assign row_sel        = row_sel_q;
  assign panel_clk      = pclk_q;
  assign panel_lat      = plat_q;
  assign panel_oe       = poe_q;
  assign frame_start    = fs_q;

endmodule

// File: doc/panel_scan.md
Name: panel_scan

Overview:
- Reader end of the double-buffered 32x16 RGB framebuffer that the pattern generator writes.
- Scans the framebuffer and drives a 1/8-scan HUB75-style LED panel.
- Rows r and r+8 are shifted together.
- Brightness comes from binary-coded modulation (BCM) over BITS bitplanes per row.
- The writer's `display` flag picks which framebuffer bank is read. It is sampled only at frame boundaries, so a frame never tears.

Parameters:
- BITS, 8, bitplanes per channel (1..8); plane p compares channel bit (8-BITS+p).
- BASE, 4, OE-low cycles for plane 0; plane p is lit for BASE<<p cycles.
- COLS, 32, columns shifted per plane; fixed at 32 to match the 5-bit column field.

Ports:
- pixclk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- display  in  1  bank select from the writer; asynchronous to pixclk.
- rd_bank  out  1  bank currently being read.
- rd_addr_top  out  9  {1'b0,row[2:0],col[4:0]}; framebuffer rows 0-7.
- rd_addr_bot  out  9  {1'b1,row[2:0],col[4:0]}; framebuffer rows 8-15.
- rgb_top  in  24  pixel at rd_addr_top; valid 1 cycle after the address; R=[23:16], G=[15:8], B=[7:0].
- rgb_bot  in  24  pixel at rd_addr_bot; same timing.
- r1,g1,b1  out  1 each  upper-half colour bits.
- r2,g2,b2  out  1 each  lower-half colour bits.
- row_sel  out  3  panel A/B/C row address.
- panel_clk  out  1  shift clock.
- panel_lat  out  1  latch strobe.
- panel_oe  out  1  active-low output enable (1 = blanked).
- frame_start  out  1  1-cycle pulse at the start of row 0 plane 0.

Behaviour:
- Reset values: all outputs 0 except panel_oe=1. Internal row=0, plane=0, col=0, state=SHIFT.
- display input: passes through a 2-flop synchronizer.
- FSM states: SHIFT -> LATCH -> SHOW -> (next plane or next row) -> SHIFT.
- SHIFT: 2*COLS+1 cycles.
  - Cycle 0 is the read prefetch.
  - Each column then takes 2 cycles: panel_clk=0 with new data bits, then panel_clk=1.
  - Exactly 32 rising edges of panel_clk per plane.
  - Data bits are stable from 1 cycle before each rising edge until the next falling edge.
  - Colour bit for plane p = channel bit (8-BITS+p), compared per channel, top and bottom independently.
  - panel_oe=1 throughout; the design does not shift during display.
- LATCH: 1 cycle, panel_lat=1, panel_clk=0, panel_oe=1.
  - row_sel updates to the current row here, and only here.
- SHOW: panel_oe=0 for exactly BASE<<plane cycles, then panel_oe=1.
  - After SHOW: plane increments. At plane BITS-1 it wraps to 0 and row increments (7 wraps to 0).
- Frame boundary:
  - On entering SHIFT for row 0 plane 0, frame_start pulses.
  - rd_bank is loaded from the synchronized display in that same cycle.
  - rd_bank is constant for the rest of the frame; display toggles mid-frame are ignored until the next boundary.
- Cycle counts:
  - Plane p: 65+1+(BASE<<p) cycles.
  - Defaults: 1548 cycles per row, 12384 per frame.
- Outside SHIFT: panel_clk=0. Outside LATCH: panel_lat=0.
- Reset mid-operation: on the next edge all outputs return to reset values (panel_oe=1 immediately) and the scan restarts at row 0 plane 0 SHIFT.
- Invariants:
  - panel_lat and panel_oe=0 never coincide.
  - row_sel never changes while panel_oe=0.
- No backpressure. The framebuffer read port always answers in 1 cycle.

Optional Feature:
- Macro PANEL_SCAN_GAMMA_EN.
- When defined, each 8-bit channel is replaced by (c*c)>>8 before the bitplane compare.
  - The result is registered in the read pipeline; SHIFT length grows to 2*COLS+2 (prefetch 2 cycles).
  - Examples: 0xFF->0xFE, 0x80->0x40, 0x01->0x00.
- When undefined, channels are used raw and SHIFT is 2*COLS+1 cycles.

Test Plan:
- Reset held 3 cycles then released -> panel_oe=1, panel_lat=0, panel_clk=0; first rd_addr_top=0, rd_addr_bot=256; frame_start pulses once.
- rgb_top=0xFF0000, rgb_bot=0x0000FF, defaults -> every plane: 32 panel_clk edges with r1=1, b2=1, others 0; SHOW widths 4,8,16,...,512; frame_start period 12384 cycles.
- rgb_top R=0x05, all else 0 -> r1=1 only in planes 0 and 2; row_sel runs 0..7 then back to 0, changing only in LATCH cycles with panel_oe=1.
- display toggled 0->1 at cycle 3000 -> rd_bank stays 0 until the next frame_start, then 1; rd_addr_* unaffected otherwise.
- Assert reset in the middle of a SHOW of plane 5 -> next cycle panel_oe=1, row_sel=0; the following frame restarts with full 12384-cycle period.
- PANEL_SCAN_GAMMA_EN defined, rgb_top=0x800000 -> r1=1 only in plane 6; SHIFT measures 66 cycles.
